// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential multiplier.
// State encoding, MUL loop length and counter width.
package mult_pkg;

  localparam int MUL_CYCLES = 32;
  localparam int CNT_W      = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEG_A  = 3'd1,
    NEG_B  = 3'd2,
    MUL    = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/adder_32_bit.sv
// 32-bit ripple-style adder with carry in/out.
// The single arithmetic resource shared by the multiplier.
module adder_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};

endmodule

// File: rtl/seq_mult_ctrl.sv
// Multi-cycle 32x32->64 shift-add multiplier controller.
// One adder is time-shared for negations and partial sums.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mc;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic               neg_a;
  logic               neg_b;
  logic               neg_r;
  logic               carry;

  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   sum;
  logic               c_out;

  logic               in_neg_a;
  logic               in_neg_b;

  assign in_neg_a = signed_mode & a[WIDTH-1];
  assign in_neg_b = signed_mode & b[WIDTH-1];

  adder_32_bit u_add (
    .a     (add_a),
    .b     (add_b),
    .c_in  (add_cin),
    .sum   (sum),
    .c_out (c_out)
  );

  always_comb begin
    state_nx = state;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (in_neg_a)      state_nx = NEG_A;
          else if (in_neg_b) state_nx = NEG_B;
          else               state_nx = MUL;
        end
      end
      NEG_A: begin
        add_a    = ~mc;
        add_cin  = 1'b1;
        state_nx = neg_b ? NEG_B : MUL;
      end
      NEG_B: begin
        add_a    = ~p_lo;
        add_cin  = 1'b1;
        state_nx = MUL;
      end
      MUL: begin
        add_a = p_hi;
        add_b = p_lo[0] ? mc : '0;
        if (count == CNT_W'(MUL_CYCLES - 1))
          state_nx = neg_r ? NEG_LO : DONE;
      end
      NEG_LO: begin
        add_a    = ~p_lo;
        add_cin  = 1'b1;
        state_nx = NEG_HI;
      end
      NEG_HI: begin
        // carry from the low half completes the 64-bit negation
        add_a    = ~p_hi;
        add_cin  = carry;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      mc      <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      neg_r   <= 1'b0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state != IDLE) && (state != DONE);
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            mc    <= a;
            p_lo  <= b;
            p_hi  <= '0;
            count <= '0;
            carry <= 1'b0;
            neg_a <= in_neg_a;
            neg_b <= in_neg_b;
            neg_r <= in_neg_a ^ in_neg_b;
          end
        end
        NEG_A: mc <= sum;
        NEG_B: p_lo <= sum;
        MUL: begin
          p_hi  <= {c_out, sum[WIDTH-1:1]};
          p_lo  <= {sum[0], p_lo[WIDTH-1:1]};
          count <= count + 1'b1;
        end
        NEG_LO: begin
          p_lo  <= sum;
          carry <= c_out;
        end
        NEG_HI:  p_hi <= sum;
        DONE:    product <= {p_hi, p_lo};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl.
// Expected products and latencies are queued at issue, popped at done.
module tb_seq_mult_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic [63:0] exp_p[$];
  int          exp_lat[$];

  seq_mult_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic sm);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0] ep;
    logic na;
    logic nb;
    @(negedge clk);
    a = ia;
    b = ib;
    signed_mode = sm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc_cyc = cyc;
    na = sm & ia[31];
    nb = sm & ib[31];
    if (sm) begin
      sa = {{32{ia[31]}}, ia};
      sb = {{32{ib[31]}}, ib};
      ep = sa * sb;
    end else begin
      ep = {32'd0, ia} * {32'd0, ib};
    end
    exp_p.push_back(ep);
    exp_lat.push_back(33 + int'(na) + int'(nb) + ((na ^ nb) ? 2 : 0));
  endtask

  task automatic wait_done(output logic [63:0] p, output int lat,
                           output int busy_err, output bit to);
    int el;
    el = (exp_lat.size() > 0) ? exp_lat[0] : 33;
    p = '0;
    lat = 0;
    busy_err = 0;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      lat = cyc - acc_cyc;
      if (busy !== ((lat >= 1) && (lat < el))) busy_err++;
      if (done === 1'b1) begin
        p = product;
        to = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b want=0", done);
    end
    checks++;
    if (product !== 64'd0) begin
      errors++;
      $display("FAIL reset_product got=%h want=0", product);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_table(input string name, input logic [31:0] ta[],
                           input logic [31:0] tb[], input logic sm);
    logic [63:0] p;
    logic [63:0] ep;
    int lat;
    int el;
    int be;
    bit to;
    for (int i = 0; i < ta.size(); i++) begin
      issue(ta[i], tb[i], sm);
      wait_done(p, lat, be, to);
      ep = exp_p.pop_front();
      el = exp_lat.pop_front();
      checks++;
      if (to) begin
        errors++;
        $display("FAIL %s_%0d_timeout got=no_done want=done", name, i);
      end
      checks++;
      if (p !== ep) begin
        errors++;
        $display("FAIL %s_%0d_product got=%h want=%h", name, i, p, ep);
      end
      checks++;
      if (lat !== el) begin
        errors++;
        $display("FAIL %s_%0d_latency got=%0d want=%0d", name, i, lat, el);
      end
      checks++;
      if (be !== 0) begin
        errors++;
        $display("FAIL %s_%0d_busy got=%0d_bad_cycles want=0", name, i, be);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL %s_%0d_pulse got=%b want=0", name, i, done);
      end
    end
  endtask

  task automatic test_unsigned;
    logic [31:0] ta[] = '{32'd7, 32'hFFFF_FFFF};
    logic [31:0] tb[] = '{32'd6, 32'hFFFF_FFFF};
    run_table("unsigned", ta, tb, 1'b0);
  endtask

  task automatic test_signed;
    logic [31:0] ta[] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd0, 32'hFFFF_FFF9};
    logic [31:0] tb[] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFF7, 32'hFFFF_FFF5};
    run_table("signed", ta, tb, 1'b1);
  endtask

  task automatic test_start_during_busy;
    logic [63:0] p;
    logic [63:0] ep;
    int lat;
    int el;
    int be;
    int extra;
    bit to;
    issue(32'd100, 32'd200, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a = 32'd5;
    b = 32'd9;
    repeat (20) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    wait_done(p, lat, be, to);
    ep = exp_p.pop_front();
    el = exp_lat.pop_front();
    checks++;
    if (to || p !== ep) begin
      errors++;
      $display("FAIL busy_start_product got=%h want=%h", p, ep);
    end
    checks++;
    if (lat !== el) begin
      errors++;
      $display("FAIL busy_start_latency got=%0d want=%0d", lat, el);
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_start_queued got=%0d want=0", extra);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [63:0] p;
    logic [63:0] ep;
    int lat;
    int el;
    int be;
    int extra;
    bit to;
    issue(32'd1234, 32'd5678, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_busy got=%b want=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_done got=%b want=0", done);
    end
    checks++;
    if (product !== 64'd0) begin
      errors++;
      $display("FAIL midrst_product got=%h want=0", product);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_p.delete();
    exp_lat.delete();
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL midrst_no_done got=%0d want=0", extra);
    end
    issue(32'd2, 32'd3, 1'b0);
    wait_done(p, lat, be, to);
    ep = exp_p.pop_front();
    el = exp_lat.pop_front();
    checks++;
    if (to || p !== ep) begin
      errors++;
      $display("FAIL midrst_after_product got=%h want=%h", p, ep);
    end
    checks++;
    if (lat !== el) begin
      errors++;
      $display("FAIL midrst_after_latency got=%0d want=%0d", lat, el);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_start_during_busy();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
